// File: rtl/conv_layer_multi_p_if.sv
// Handshake and data buses between the image buffer / host and the
// multi-lane convolution layer.
interface conv_layer_multi_p_if #(
  parameter int DATA_WIDTH = 16,
  parameter int D          = 1,
  parameter int H          = 32,
  parameter int W          = 32,
  parameter int F          = 5,
  parameter int K          = 6,
  parameter int S          = 1
);
  localparam int OH = (H - F) / S + 1;
  localparam int OW = (W - F) / S + 1;
  localparam int T  = D * F * F;

  logic                              start;
  logic                              busy;
  logic                              done;
  logic [D*H*W*DATA_WIDTH-1:0]       image;
  logic [K*T*DATA_WIDTH-1:0]         filters;
  logic [K*OH*OW*DATA_WIDTH-1:0]     outputConv;

  modport master (output start, image, filters, input busy, done, outputConv);
  modport slave  (input start, image, filters, output busy, done, outputConv);
endinterface

// File: rtl/conv_layer_multi_p.sv
// Multi-filter convolution layer: K filters over a D-channel HxW image,
// P filters in flight at once (one MAC lane each), one tap per cycle.
// Flat buses hold element 0 at the MSB end.

// One MAC lane: signed accumulate, then Q-format rescale with saturation.
module conv_lane #(
  parameter int DW   = 16,
  parameter int FRAC = 8,
  parameter int T    = 25
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clr,
  input  logic          i_mac,
  input  logic [DW-1:0] i_sample,
  input  logic [DW-1:0] i_weight,
  output logic [DW-1:0] o_result
);
  localparam int AW = 2*DW + $clog2(T) + 1;
  localparam logic signed [AW-1:0] MAXV = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [2*DW-1:0] w_a, w_b, w_prod;
  logic signed [AW-1:0]   r_acc, w_shift;

  assign w_a     = {{DW{i_sample[DW-1]}}, i_sample};
  assign w_b     = {{DW{i_weight[DW-1]}}, i_weight};
  assign w_prod  = w_a * w_b;
  assign w_shift = r_acc >>> FRAC;

  // Accumulator: cleared at run start and after each pixel write.
  always_ff @(posedge clk) begin
    if (!reset)     r_acc <= '0;
    else if (i_clr) r_acc <= '0;
    else if (i_mac) r_acc <= r_acc + {{(AW-2*DW){w_prod[2*DW-1]}}, w_prod};
  end

  // Clamp the rescaled sum into the DW-bit signed range.
  always_comb begin
    o_result = w_shift[DW-1:0];
    if (w_shift > MAXV)      o_result = MAXV[DW-1:0];
    else if (w_shift < MINV) o_result = MINV[DW-1:0];
  end
endmodule

module conv_layer_multi_p #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC       = 8,
  parameter int D          = 1,
  parameter int H          = 32,
  parameter int W          = 32,
  parameter int F          = 5,
  parameter int K          = 6,
  parameter int P          = 2,
  parameter int S          = 1
) (
  input logic                 clk,
  input logic                 reset,
  conv_layer_multi_p_if.slave bus
);
  localparam int DW  = DATA_WIDTH;
  localparam int OH  = (H - F) / S + 1;
  localparam int OW  = (W - F) / S + 1;
  localparam int T   = D * F * F;
  localparam int G   = (K + P - 1) / P;
  localparam int NI  = D * H * W;
  localparam int NF  = K * T;
  localparam int NO  = K * OH * OW;
  localparam int GW  = $clog2(G + 1);
  localparam int RW  = $clog2(OH + 1);
  localparam int CW  = $clog2(OW + 1);
  localparam int DCW = $clog2(D + 1);
  localparam int FW  = $clog2(F + 1);
  localparam int TW  = $clog2(T + 1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_WRITE, S_DONE} state_t;

  state_t                r_state, w_next;
  logic [GW-1:0]         r_g;
  logic [RW-1:0]         r_r;
  logic [CW-1:0]         r_c;
  logic [DCW-1:0]        r_ch;
  logic [FW-1:0]         r_fr, r_fc;
  logic [TW-1:0]         r_t;
  logic [NO*DW-1:0]      r_out;

  logic                  w_accept, w_last_tap, w_last_c, w_last_r, w_last_g;
  logic [P-1:0]          w_en;
  logic [P-1:0][DW-1:0]  w_weight, w_result;
  logic [DW-1:0]         w_sample;
  int                    w_iidx;
  int                    w_widx [P];
  int                    w_oidx [P];

  assign w_accept   = (r_state == S_IDLE) && bus.start;
  assign w_last_tap = (r_t  == TW'(T - 1));
  assign w_last_c   = (r_c  == CW'(OW - 1));
  assign w_last_r   = (r_r  == RW'(OH - 1));
  assign w_last_g   = (r_g  == GW'(G - 1));

  assign bus.busy       = (r_state == S_MAC) || (r_state == S_WRITE);
  assign bus.done       = (r_state == S_DONE);
  assign bus.outputConv = r_out;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state: T MAC cycles then one WRITE per output pixel, group by group.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_MAC;
      S_MAC:   if (w_last_tap) w_next = S_WRITE;
      S_WRITE: w_next = (w_last_c && w_last_r && w_last_g) ? S_DONE : S_MAC;
      default: w_next = S_IDLE;
    endcase
  end

  // Tap walk (channel, row, column) inside MAC; pixel/group walk on WRITE.
  always_ff @(posedge clk) begin
    if (!reset || w_accept) begin
      r_g <= '0; r_r <= '0; r_c <= '0;
      r_ch <= '0; r_fr <= '0; r_fc <= '0; r_t <= '0;
    end else if (r_state == S_MAC) begin
      if (w_last_tap) begin
        r_ch <= '0; r_fr <= '0; r_fc <= '0; r_t <= '0;
      end else begin
        r_t <= r_t + 1'b1;
        if (r_fc == FW'(F - 1)) begin
          r_fc <= '0;
          if (r_fr == FW'(F - 1)) begin
            r_fr <= '0;
            r_ch <= r_ch + 1'b1;
          end else begin
            r_fr <= r_fr + 1'b1;
          end
        end else begin
          r_fc <= r_fc + 1'b1;
        end
      end
    end else if (r_state == S_WRITE) begin
      if (!w_last_c) r_c <= r_c + 1'b1;
      else begin
        r_c <= '0;
        if (!w_last_r) r_r <= r_r + 1'b1;
        else begin
          r_r <= '0;
          r_g <= w_last_g ? '0 : r_g + 1'b1;
        end
      end
    end
  end

  // Operand fetch: shared image sample, per-lane weight and output slot.
  // Lanes past the last filter are disabled and point at index 0.
  always_comb begin
    w_iidx   = int'(r_ch) * H * W + (int'(r_r) * S + int'(r_fr)) * W
             + int'(r_c) * S + int'(r_fc);
    w_sample = bus.image[(NI - 1 - w_iidx) * DW +: DW];
    for (int j = 0; j < P; j++) begin
      w_en[j]     = (int'(r_g) * P + j) < K;
      w_widx[j]   = w_en[j] ? (int'(r_g) * P + j) * T + int'(r_t) : 0;
      w_oidx[j]   = w_en[j] ? (int'(r_g) * P + j) * OH * OW + int'(r_r) * OW + int'(r_c) : 0;
      w_weight[j] = bus.filters[(NF - 1 - w_widx[j]) * DW +: DW];
    end
  end

  for (genvar j = 0; j < P; j++) begin : g_lane
    conv_lane #(.DW(DW), .FRAC(FRAC), .T(T)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .i_clr    (w_accept || (r_state == S_WRITE)),
      .i_mac    ((r_state == S_MAC) && w_en[j]),
      .i_sample (w_sample),
      .i_weight (w_weight[j]),
      .o_result (w_result[j])
    );
  end

  // Result store: enabled lanes write their pixel during WRITE.
  always_ff @(posedge clk) begin
    if (!reset) r_out <= '0;
    else if (r_state == S_WRITE)
      for (int j = 0; j < P; j++)
        if (w_en[j]) r_out[(NO - 1 - w_oidx[j]) * DW +: DW] <= w_result[j];
  end
endmodule

// File: tb/tb_conv_layer_multi_p.sv
// Scoreboard bench for conv_layer_multi_p: four instances cover the base
// config, strided config, and P=3 vs P=1 on the same stimulus.
module tb_conv_layer_multi_p;
  localparam int DW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   sb_q[$];
  int   ia[$], fa[$], ib[$], fb[$], ic[$], fcq[$];

  always #5 clk = ~clk;

  conv_layer_multi_p_if #(.DATA_WIDTH(DW), .D(1), .H(4), .W(4), .F(2), .K(3), .S(1)) ifa ();
  conv_layer_multi_p_if #(.DATA_WIDTH(DW), .D(1), .H(5), .W(5), .F(3), .K(2), .S(2)) ifb ();
  conv_layer_multi_p_if #(.DATA_WIDTH(DW), .D(1), .H(4), .W(4), .F(2), .K(3), .S(1)) ifc ();
  conv_layer_multi_p_if #(.DATA_WIDTH(DW), .D(1), .H(4), .W(4), .F(2), .K(3), .S(1)) ifd ();

  conv_layer_multi_p #(.DATA_WIDTH(DW), .FRAC(8), .D(1), .H(4), .W(4), .F(2), .K(3), .P(2), .S(1))
    u_dut_a (.clk(clk), .reset(rst_n), .bus(ifa));
  conv_layer_multi_p #(.DATA_WIDTH(DW), .FRAC(8), .D(1), .H(5), .W(5), .F(3), .K(2), .P(2), .S(2))
    u_dut_b (.clk(clk), .reset(rst_n), .bus(ifb));
  conv_layer_multi_p #(.DATA_WIDTH(DW), .FRAC(8), .D(1), .H(4), .W(4), .F(2), .K(3), .P(3), .S(1))
    u_dut_c (.clk(clk), .reset(rst_n), .bus(ifc));
  conv_layer_multi_p #(.DATA_WIDTH(DW), .FRAC(8), .D(1), .H(4), .W(4), .F(2), .K(3), .P(1), .S(1))
    u_dut_d (.clk(clk), .reset(rst_n), .bus(ifd));

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int s16(input int v);
    return int'($signed(16'(v)));
  endfunction

  // Reference pixel: full-precision sum, >>> 8, saturate to 16-bit signed.
  function automatic int ref_px(input int img[$], input int flt[$],
                                input int D, input int H, input int W, input int F,
                                input int S, input int k, input int r, input int c);
    longint acc = 0;
    int     t   = D * F * F;
    for (int ch = 0; ch < D; ch++)
      for (int fr = 0; fr < F; fr++)
        for (int fc = 0; fc < F; fc++)
          acc += longint'(img[ch*H*W + (r*S+fr)*W + c*S+fc]) *
                 longint'(flt[k*t + ch*F*F + fr*F + fc]);
    acc = acc >>> 8;
    if (acc > 32767)  return 32767;
    if (acc < -32768) return -32768;
    return int'(acc);
  endfunction

  task automatic push_exp(input int img[$], input int flt[$], input int D, input int H,
                          input int W, input int F, input int S, input int K);
    int oh = (H - F) / S + 1;
    int ow = (W - F) / S + 1;
    for (int k = 0; k < K; k++)
      for (int r = 0; r < oh; r++)
        for (int c = 0; c < ow; c++)
          sb_q.push_back(ref_px(img, flt, D, H, W, F, S, k, r, c) & 'hFFFF);
  endtask

  task automatic chk_out(input string tag, input logic [27*DW-1:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      int e = sb_q.pop_front();
      chk($sformatf("%s[%0d]", tag, i), longint'(v[(n-1-i)*DW +: DW]), longint'(e));
    end
  endtask

  task automatic load_a();
    for (int i = 0; i < 16; i++) ifa.image[(15-i)*DW +: DW] = 16'(ia[i]);
    for (int i = 0; i < 12; i++) ifa.filters[(11-i)*DW +: DW] = 16'(fa[i]);
  endtask

  task automatic fill_t1();
    ia = {}; fa = {};
    for (int i = 0; i < 16; i++) ia.push_back(s16('h0100));
    for (int i = 0; i < 12; i++) fa.push_back(s16('h0100));
  endtask

  // One start pulse on instance A; returns busy-cycle count and done cycle.
  task automatic run_a(output int nb, output int td);
    nb = 0; td = -1;
    @(negedge clk); ifa.start = 1'b1;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk); ifa.start = 1'b0;
      if (ifa.busy) nb++;
      if (ifa.done) begin td = n; break; end
    end
  endtask

  initial begin
    int nb, td, nd, d1, d2, b92, b93, nbc, nbd, tdc, tdd;
    ifa.start = 0; ifb.start = 0; ifc.start = 0; ifd.start = 0;
    ifa.image = '0; ifa.filters = '0; ifb.image = '0; ifb.filters = '0;
    ifc.image = '0; ifc.filters = '0; ifd.image = '0; ifd.filters = '0;

    repeat (3) @(negedge clk);
    chk("rst_busy", ifa.busy, 0);
    chk("rst_done", ifa.done, 0);
    chk("rst_oc",   |ifa.outputConv, 0);
    rst_n = 1'b1;

    // Unit image and filters: each output is 4 * 1.0 = 4.0.
    fill_t1(); load_a(); push_exp(ia, fa, 1, 4, 4, 2, 1, 3);
    run_a(nb, td);
    chk("t1_busy_cycles", nb, 90);
    chk("t1_done_cycle",  td, 91);
    @(negedge clk);
    chk("t1_done_pulse", ifa.done, 0);
    chk("t1_busy_after", ifa.busy, 0);
    chk("t1_last_px", ifa.outputConv[0 +: DW], 'h0400);
    chk_out("t1_oc", ifa.outputConv, 27);

    // Saturation both ways.
    ia = {}; fa = {};
    for (int i = 0; i < 16; i++) ia.push_back(s16('h7FFF));
    for (int i = 0; i < 4; i++) fa.push_back(s16('h7FFF));
    for (int i = 0; i < 4; i++) fa.push_back(s16('h8001));
    for (int i = 0; i < 4; i++) fa.push_back(s16('h0100));
    load_a(); push_exp(ia, fa, 1, 4, 4, 2, 1, 3);
    run_a(nb, td);
    chk("t2_done_cycle", td, 91);
    chk("t2_sat_pos", ifa.outputConv[26*DW +: DW], 'h7FFF);
    chk("t2_sat_neg", ifa.outputConv[17*DW +: DW], 'h8000);
    chk_out("t2_oc", ifa.outputConv, 27);

    // Reset pulse during group 1 abandons the run.
    fill_t1(); load_a();
    @(negedge clk); ifa.start = 1'b1;
    @(negedge clk); ifa.start = 1'b0;
    repeat (49) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_busy", ifa.busy, 0);
    chk("mid_rst_oc",   |ifa.outputConv, 0);
    nd = 0;
    repeat (120) begin
      @(negedge clk);
      if (ifa.done) nd++;
    end
    chk("mid_rst_no_done", nd, 0);
    push_exp(ia, fa, 1, 4, 4, 2, 1, 3);
    run_a(nb, td);
    chk("rerun_busy_cycles", nb, 90);
    chk("rerun_done_cycle",  td, 91);
    chk_out("rerun_oc", ifa.outputConv, 27);

    // Start held high: back-to-back runs, one done each, resampled in IDLE.
    @(negedge clk); ifa.start = 1'b1;
    nb = 0; nd = 0; d1 = -1; d2 = -1; b92 = -1; b93 = -1;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (ifa.busy) nb++;
      if (ifa.done) begin
        nd++;
        if (d1 < 0) d1 = n; else if (d2 < 0) d2 = n;
      end
      if (d1 > 0 && n == d1 + 1) b92 = ifa.busy;
      if (d1 > 0 && n == d1 + 2) b93 = ifa.busy;
      if (d2 > 0 && n == d2 + 1) ifa.start = 1'b0;
      if (d2 > 0 && n == d2 + 10) break;
    end
    ifa.start = 1'b0;
    chk("hold_done1", d1, 91);
    chk("hold_done2", d2, 183);
    chk("hold_ndone", nd, 2);
    chk("hold_busy_total", nb, 180);
    chk("hold_idle_gap", b92, 0);
    chk("hold_restart", b93, 1);
    push_exp(ia, fa, 1, 4, 4, 2, 1, 3);
    chk_out("hold_oc", ifa.outputConv, 27);

    // Stride 2: ramp image, filter 0 is a single centre tap.
    ib = {}; fb = {};
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) ib.push_back((r*5 + c) << 8);
    for (int i = 0; i < 9; i++) fb.push_back(i == 4 ? 'h0100 : 0);
    for (int i = 0; i < 9; i++) fb.push_back(int'($urandom_range(0, 511)) - 256);
    for (int i = 0; i < 25; i++) ifb.image[(24-i)*DW +: DW] = 16'(ib[i]);
    for (int i = 0; i < 18; i++) ifb.filters[(17-i)*DW +: DW] = 16'(fb[i]);
    push_exp(ib, fb, 1, 5, 5, 3, 2, 2);
    @(negedge clk); ifb.start = 1'b1;
    nb = 0; td = -1;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk); ifb.start = 1'b0;
      if (ifb.busy) nb++;
      if (ifb.done) begin td = n; break; end
    end
    chk("s2_busy_cycles", nb, 40);
    chk("s2_done_cycle",  td, 41);
    chk("s2_px0", ifb.outputConv[7*DW +: DW], 'h0600);
    chk("s2_px1", ifb.outputConv[6*DW +: DW], 'h0800);
    chk("s2_px2", ifb.outputConv[5*DW +: DW], 'h1000);
    chk("s2_px3", ifb.outputConv[4*DW +: DW], 'h1200);
    chk_out("s2_oc", {{(27-8)*DW{1'b0}}, ifb.outputConv}, 8);

    // P=3 vs P=1 on identical random stimulus.
    ic = {}; fcq = {};
    for (int i = 0; i < 16; i++) ic.push_back(int'($urandom_range(0, 1023)) - 512);
    for (int i = 0; i < 12; i++) fcq.push_back(int'($urandom_range(0, 1023)) - 512);
    for (int i = 0; i < 16; i++) begin
      ifc.image[(15-i)*DW +: DW] = 16'(ic[i]);
      ifd.image[(15-i)*DW +: DW] = 16'(ic[i]);
    end
    for (int i = 0; i < 12; i++) begin
      ifc.filters[(11-i)*DW +: DW] = 16'(fcq[i]);
      ifd.filters[(11-i)*DW +: DW] = 16'(fcq[i]);
    end
    push_exp(ic, fcq, 1, 4, 4, 2, 1, 3);
    push_exp(ic, fcq, 1, 4, 4, 2, 1, 3);
    @(negedge clk); ifc.start = 1'b1; ifd.start = 1'b1;
    nbc = 0; nbd = 0; tdc = -1; tdd = -1;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk); ifc.start = 1'b0; ifd.start = 1'b0;
      if (ifc.busy) nbc++;
      if (ifd.busy) nbd++;
      if (ifc.done) tdc = n;
      if (ifd.done) tdd = n;
      if (tdc >= 0 && tdd >= 0) break;
    end
    chk("p3_busy_cycles", nbc, 45);
    chk("p1_busy_cycles", nbd, 135);
    chk("p3_done_cycle",  tdc, 46);
    chk("p1_done_cycle",  tdd, 136);
    chk_out("p3_oc", ifc.outputConv, 27);
    chk_out("p1_oc", ifd.outputConv, 27);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
